// File: rtl/imm_gen_if.sv
// Bus for the RV64I immediate generator: instruction word in, combinational
// immediate/format/illegal out, plus the registered copies for the execute stage.
interface imm_gen_if;
   logic [31:0] in_t;
   logic        in_valid;
   logic [63:0] out_t;
   logic [2:0]  fmt;
   logic        illegal;
   logic [63:0] imm_q;
   logic [2:0]  fmt_q;
   logic        illegal_q;
   logic        valid_q;

   modport master (
      output in_t, in_valid,
      input  out_t, fmt, illegal, imm_q, fmt_q, illegal_q, valid_q
   );

   modport slave (
      input  in_t, in_valid,
      output out_t, fmt, illegal, imm_q, fmt_q, illegal_q, valid_q
   );
endinterface

// File: rtl/imm_gen.sv
// RV64I immediate generator: decodes the opcode, extracts and sign-extends the
// I/S/B/U/J immediate, and registers it once. Optional macro: IMM_SHAMT_EN.
module imm_gen (
   input  logic      clk,
   input  logic      reset,
   imm_gen_if.slave  bus
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5,
      FMT_X = 3'd7
   } fmt_t;

   function automatic logic signed [63:0] sext12(input logic [11:0] f);
      return {{52{f[11]}}, f};
   endfunction

   function automatic logic signed [63:0] sext13(input logic [12:0] f);
      return {{51{f[12]}}, f};
   endfunction

   function automatic logic signed [63:0] sext21(input logic [20:0] f);
      return {{43{f[20]}}, f};
   endfunction

   function automatic logic signed [63:0] sext32(input logic [31:0] f);
      return {{32{f[31]}}, f};
   endfunction

   logic [31:0]        ins;
   logic [6:0]         opcode;
   logic signed [63:0] imm_i;
   logic signed [63:0] imm_s;
   logic signed [63:0] imm_b;
   logic signed [63:0] imm_u;
   logic signed [63:0] imm_j;
   logic signed [63:0] imm;
   fmt_t               fmt_code;
   logic               bad_op;

   assign ins    = bus.in_t;
   assign opcode = ins[6:0];

   assign imm_i = sext12(ins[31:20]);
   assign imm_s = sext12({ins[31:25], ins[11:7]});
   assign imm_b = sext13({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
   assign imm_u = sext32({ins[31:12], 12'b0});
   assign imm_j = sext21({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});

   // Unknown opcodes still produce the I-format extraction so the datapath sees a defined value.
   always_comb begin
      imm      = imm_i;
      fmt_code = FMT_X;
      bad_op   = 1'b1;
      unique case (opcode)
         7'b0000011, 7'b1100111, 7'b1110011: begin
            fmt_code = FMT_I;
            bad_op   = 1'b0;
         end
         7'b0010011: begin
            fmt_code = FMT_I;
            bad_op   = 1'b0;
`ifdef IMM_SHAMT_EN
            if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101)
               imm = {58'b0, ins[25:20]};
`endif
         end
         7'b0011011: begin
            fmt_code = FMT_I;
            bad_op   = 1'b0;
`ifdef IMM_SHAMT_EN
            if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101)
               imm = {59'b0, ins[24:20]};
`endif
         end
         7'b0100011: begin
            imm      = imm_s;
            fmt_code = FMT_S;
            bad_op   = 1'b0;
         end
         7'b1100011: begin
            imm      = imm_b;
            fmt_code = FMT_B;
            bad_op   = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            imm      = imm_u;
            fmt_code = FMT_U;
            bad_op   = 1'b0;
         end
         7'b1101111: begin
            imm      = imm_j;
            fmt_code = FMT_J;
            bad_op   = 1'b0;
         end
         7'b0110011, 7'b0111011: begin
            imm      = '0;
            fmt_code = FMT_R;
            bad_op   = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.out_t   = imm;
   assign bus.fmt     = fmt_code;
   assign bus.illegal = bad_op;

   // Output register stage feeding execute; reset wins over a simultaneous capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.imm_q     <= '0;
         bus.fmt_q     <= '0;
         bus.illegal_q <= 1'b0;
         bus.valid_q   <= 1'b0;
      end else begin
         bus.valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            bus.imm_q     <= imm;
            bus.fmt_q     <= fmt_code;
            bus.illegal_q <= bad_op;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed spec vectors, register behaviour,
// and randomized instructions against an arithmetic reference model.
module tb_imm_gen;

   logic clk = 1'b0;
   logic reset;

   imm_gen_if bus ();

   imm_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_imm_q;
   logic [2:0]  m_fmt_q;
   logic        m_ill_q;
   logic        m_vld_q;

   // Reference: immediates rebuilt as signed integer sums of weighted fields.
   function automatic void ref_model(input logic [31:0] w, output logic [63:0] imm,
                                     output logic [2:0] f, output logic ill);
      longint v_i, v;
      v_i = longint'($signed(w)) >>> 20;
      v   = v_i;
      f   = 3'd7;
      ill = 1'b1;
      case (w[6:0])
         7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
            f = 3'd1; ill = 1'b0;
`ifdef IMM_SHAMT_EN
            if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
               v = longint'(w[25:20]);
            if (w[6:0] == 7'h1B && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
               v = longint'(w[24:20]);
`endif
         end
         7'h23: begin
            f = 3'd2; ill = 1'b0;
            v = ((longint'($signed(w)) >>> 25) * 32) + longint'(w[11:7]);
         end
         7'h63: begin
            f = 3'd3; ill = 1'b0;
            v = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048
              + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
         end
         7'h37, 7'h17: begin
            f = 3'd4; ill = 1'b0;
            v = longint'($signed(w & 32'hFFFF_F000));
         end
         7'h6F: begin
            f = 3'd5; ill = 1'b0;
            v = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096
              + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
         end
         7'h33, 7'h3B: begin
            f = 3'd0; ill = 1'b0;
            v = 0;
         end
         default: ;
      endcase
      imm = 64'(v);
   endfunction

   task automatic test_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_t     = 32'h0050_0013;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.imm_q !== 64'd0 || bus.valid_q !== 1'b0 || bus.fmt_q !== 3'd0 || bus.illegal_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: imm_q=%h fmt_q=%0d illegal_q=%b valid_q=%b, required all zero",
                  bus.imm_q, bus.fmt_q, bus.illegal_q, bus.valid_q);
      end
      checks++;
      if (bus.out_t !== 64'd5 || bus.fmt !== 3'd1) begin
         errors++;
         $display("FAIL reset_comb: out_t=%h fmt=%0d, required 5 fmt 1", bus.out_t, bus.fmt);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vec_in  [8];
      logic [63:0] vec_imm [8];
      logic [2:0]  vec_fmt [8];
      logic        vec_ill [8];
      vec_in[0] = 32'h0000_0237; vec_imm[0] = 64'h0;                   vec_fmt[0] = 3'd4; vec_ill[0] = 1'b0;
      vec_in[1] = 32'hFFFF_FFFF; vec_imm[1] = 64'hFFFF_FFFF_FFFF_FFFF; vec_fmt[1] = 3'd7; vec_ill[1] = 1'b1;
      vec_in[2] = 32'hFFF0_0013; vec_imm[2] = 64'hFFFF_FFFF_FFFF_FFFF; vec_fmt[2] = 3'd1; vec_ill[2] = 1'b0;
      vec_in[3] = 32'hFE00_2E23; vec_imm[3] = 64'hFFFF_FFFF_FFFF_FFFC; vec_fmt[3] = 3'd2; vec_ill[3] = 1'b0;
      vec_in[4] = 32'h0000_0463; vec_imm[4] = 64'h8;                   vec_fmt[4] = 3'd3; vec_ill[4] = 1'b0;
      vec_in[5] = 32'hFFFF_F06F; vec_imm[5] = 64'hFFFF_FFFF_FFFF_FFFE; vec_fmt[5] = 3'd5; vec_ill[5] = 1'b0;
      vec_in[6] = 32'h8000_0017; vec_imm[6] = 64'hFFFF_FFFF_8000_0000; vec_fmt[6] = 3'd4; vec_ill[6] = 1'b0;
      vec_in[7] = 32'h43F0_D093; vec_fmt[7] = 3'd1; vec_ill[7] = 1'b0;
`ifdef IMM_SHAMT_EN
      vec_imm[7] = 64'h3F;
`else
      vec_imm[7] = 64'h43F;
`endif
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.in_t = vec_in[i];
         #1;
         checks++;
         if (bus.out_t !== vec_imm[i] || bus.fmt !== vec_fmt[i] || bus.illegal !== vec_ill[i]) begin
            errors++;
            $display("FAIL directed_%0d in=%h: out_t=%h fmt=%0d illegal=%b, required %h fmt %0d illegal %b",
                     i, vec_in[i], bus.out_t, bus.fmt, bus.illegal, vec_imm[i], vec_fmt[i], vec_ill[i]);
         end
      end
   endtask

   task automatic test_register();
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_t     = 32'h0050_0013;
      @(negedge clk);
      checks++;
      if (bus.imm_q !== 64'd5 || bus.valid_q !== 1'b1 || bus.fmt_q !== 3'd1 || bus.illegal_q !== 1'b0) begin
         errors++;
         $display("FAIL capture: imm_q=%h valid_q=%b fmt_q=%0d, required 5 1 1", bus.imm_q, bus.valid_q, bus.fmt_q);
      end
      bus.in_valid = 1'b0;
      bus.in_t     = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (bus.imm_q !== 64'd5 || bus.valid_q !== 1'b0 || bus.fmt_q !== 3'd1 || bus.illegal_q !== 1'b0) begin
         errors++;
         $display("FAIL hold: imm_q=%h valid_q=%b fmt_q=%0d illegal_q=%b, required 5 0 1 0",
                  bus.imm_q, bus.valid_q, bus.fmt_q, bus.illegal_q);
      end
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.imm_q !== 64'd0 || bus.valid_q !== 1'b0 || bus.fmt_q !== 3'd0 || bus.illegal_q !== 1'b0) begin
         errors++;
         $display("FAIL midstream_reset: imm_q=%h valid_q=%b fmt_q=%0d illegal_q=%b, required all zero",
                  bus.imm_q, bus.valid_q, bus.fmt_q, bus.illegal_q);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.imm_q !== 64'hFFFF_FFFF_FFFF_FFFF || bus.valid_q !== 1'b1 || bus.fmt_q !== 3'd7 || bus.illegal_q !== 1'b1) begin
         errors++;
         $display("FAIL resume: imm_q=%h valid_q=%b fmt_q=%0d illegal_q=%b, required all-ones 1 7 1",
                  bus.imm_q, bus.valid_q, bus.fmt_q, bus.illegal_q);
      end
      m_imm_q = 64'hFFFF_FFFF_FFFF_FFFF;
      m_fmt_q = 3'd7;
      m_ill_q = 1'b1;
      m_vld_q = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [6:0]  ops [14];
      logic [31:0] w;
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      logic        e_ill;
      logic        v, r;
      ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
              7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h13, 7'h1B};
      for (int n = 0; n < 400; n++) begin
         w = $urandom;
         if ($urandom_range(0, 7) != 0)
            w[6:0] = ops[$urandom_range(0, 13)];
         v = ($urandom_range(0, 2) != 0);
         r = ($urandom_range(0, 15) == 0);
         bus.in_t     = w;
         bus.in_valid = v;
         reset        = r;
         #1;
         ref_model(w, e_imm, e_fmt, e_ill);
         checks++;
         if (bus.out_t !== e_imm || bus.fmt !== e_fmt || bus.illegal !== e_ill) begin
            errors++;
            $display("FAIL rand_comb in=%h: out_t=%h fmt=%0d illegal=%b, required %h fmt %0d illegal %b",
                     w, bus.out_t, bus.fmt, bus.illegal, e_imm, e_fmt, e_ill);
         end
         if (r) begin
            m_imm_q = '0; m_fmt_q = '0; m_ill_q = 1'b0; m_vld_q = 1'b0;
         end else begin
            m_vld_q = v;
            if (v) begin
               m_imm_q = e_imm; m_fmt_q = e_fmt; m_ill_q = e_ill;
            end
         end
         @(negedge clk);
         checks++;
         if (bus.imm_q !== m_imm_q || bus.fmt_q !== m_fmt_q || bus.illegal_q !== m_ill_q || bus.valid_q !== m_vld_q) begin
            errors++;
            $display("FAIL rand_reg in=%h v=%b r=%b: imm_q=%h fmt_q=%0d illegal_q=%b valid_q=%b, required %h %0d %b %b",
                     w, v, r, bus.imm_q, bus.fmt_q, bus.illegal_q, bus.valid_q,
                     m_imm_q, m_fmt_q, m_ill_q, m_vld_q);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_t     = 32'h0;
      test_reset();
      test_directed();
      test_register();
      @(negedge clk);
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
